regs_wb_ctrl: RTL and testbench
===============================

REGS_WB_CTRL -- requirements
Module: regs_wb_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; all state updates on posedge clk.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have ports: pri_we / pri_addr / pri_data  in  1/5/32  primary (ALU) writeback; no back-pressure except pri_stall.
REQ-004 SHALL have ports: sec_valid / sec_addr / sec_data  in  1/5/32  secondary (load/multicycle) writeback request.
REQ-005 SHALL have ports: sec_ready  out  1  secondary request accepted when sec_valid && sec_ready.
REQ-006 SHALL have ports: L_S / Wt_addr / Wt_data  out  1/5/32  register-file write port (write enable, address, data).
REQ-007 SHALL have ports: busy  out  32  bit i set while a live queued write targets register i; bit 0 always 0.
REQ-008 SHALL have ports: fifo_cnt  out  3  queued secondary entries (0..4).
REQ-009 SHALL have ports: pri_stall  out  1  upstream holds pri_* this cycle; the block ignores pri_we.

Function
REQ-010 SHALL buffer accepted secondary requests in a 4-entry in-order FIFO; sec_ready = (fifo_cnt < 4) && !rst, combinational.
REQ-011 SHALL accept a secondary request to sec_addr 0 (handshake completes) without enqueuing it.
REQ-012 SHALL select the write source each cycle: primary if pri_we && pri_addr != 0 && !pri_stall; else FIFO head if a live entry exists; else idle.
REQ-013 SHALL register the selected write: L_S/Wt_addr/Wt_data appear the cycle after selection (latency 1); idle drives L_S=0, Wt_addr=0, Wt_data=0.
REQ-014 SHALL never assert L_S with Wt_addr = 0.
REQ-015 SHALL, when a primary write to address X is issued, mark every queued entry targeting X as killed (the newer primary value wins).
REQ-016 SHALL pop killed entries at the head without issuing a write (one pop per cycle, consuming that cycle's FIFO slot).
REQ-017 SHALL allow push and pop in the same cycle; when full, pop in cycle N makes sec_ready high in cycle N+1, not N.
REQ-018 SHALL compute busy from live (valid, non-killed) entries only; an entry pushed in cycle N shows in busy from N+1; an entry issued clears with the write's appearance on L_S.
REQ-019 SHALL kill a same-cycle secondary push to X when a primary write to X issues that cycle.

Reset
REQ-020 SHALL, while rst is high at a clock edge: empty the FIFO, clear all kill flags and age counter, and drive L_S=0, Wt_addr=0, Wt_data=0, busy=0, fifo_cnt=0, pri_stall=0, sec_ready=0.
REQ-021 SHALL discard any in-flight or queued write on reset mid-operation; no write appears on L_S in the cycle after rst deasserts.

Configuration
REQ-022 SHALL compile a head-age starvation guard under macro REGS_WB_AGE_GUARD_EN.
REQ-023 With REGS_WB_AGE_GUARD_EN: a 3-bit counter counts cycles a live head waits unissued, clearing on pop; at AGE_LIMIT (7) pri_stall asserts the next cycle and the head issues that cycle.
REQ-024 Without REGS_WB_AGE_GUARD_EN: pri_stall is constant 0 and primary always wins.

Structure
REQ-025 SHALL place FIFO_DEPTH=4, AGE_LIMIT=7 and the FIFO entry typedef (addr, data, killed) in shared package regs_wb_pkg.
REQ-026 SHALL implement the queue as sub-module wb_fifo (push, pop, per-entry kill-by-address, count, head, live-address mask); arbitration and output registers stay in regs_wb_ctrl.

Verification
REQ-027 Reset: assert rst 2 cycles mid-traffic -> L_S=0, fifo_cnt=0, busy=0, sec_ready=0 during reset; sec_ready=1 the cycle after.
REQ-028 Priority: pri write r5=0x11 with sec push r6=0x22 in the same cycle; primary idle after -> L_S writes r5 at N+1, r6 at N+2; busy[6] high N+1 only.
REQ-029 Kill: sec push r7=0xAA, then pri r7=0xBB while r7 is queued -> only r7=0xBB written; queued r7 dropped silently; busy[7] cleared.
REQ-030 Full: pri_we held high (r1) while 5 sec pushes -> 4 accepted, sec_ready=0 at fifo_cnt=4; one pop lets the 5th accept one cycle later.
REQ-031 Address 0: pri to r0 plus sec to r0 -> no L_S assertion; sec handshake completes; fifo_cnt unchanged; queued entries drain in the r0 cycle.
REQ-032 Age guard (macro on): pri_we held high continuously with one queued entry -> pri_stall high after 7 waiting cycles; head written that cycle; macro off -> never written while pri_we stays high.

Source files
------------

// File: rtl/regs_wb_pkg.sv
// Shared constants and queue entry type for the register-file writeback controller.
package regs_wb_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int AGE_LIMIT  = 7;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              killed;
  } wb_entry_t;

endpackage

// File: rtl/regs_wb_ctrl_fifo.sv
// wb_fifo: in-order secondary writeback queue with per-entry kill-by-address
// and a mask of the register addresses still owned by live entries.
module wb_fifo
  import regs_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_kill_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] kill_addr_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_killed_o,
  output logic [31:0]       live_mask_o
);

  wb_entry_t              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_q;
  logic [PTR_W-1:0]       wr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [FIFO_DEPTH-1:0]  valid;
  logic [31:0]            live;

  // A slot is occupied when its distance from the read pointer is below the count.
  function automatic logic slot_valid(input int i, input logic [PTR_W-1:0] rd,
                                      input logic [CNT_W-1:0] cnt);
    logic [PTR_W-1:0] off;
    off = PTR_W'(i) - rd;
    return CNT_W'(off) < cnt;
  endfunction

  always_comb begin
    valid = '0;
    live  = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      valid[i] = slot_valid(i, rd_q, cnt_q);
      if (valid[i] && !mem_q[i].killed) live[mem_q[i].addr] = 1'b1;
    end
    live[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i].killed <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (kill_i && valid[i] && (mem_q[i].addr == kill_addr_i)) mem_q[i].killed <= 1'b1;
      end
      if (push_i) begin
        mem_q[wr_q] <= '{addr: push_addr_i, data: push_data_i, killed: push_kill_i};
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_i) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign cnt_o         = cnt_q;
  assign head_addr_o   = mem_q[rd_q].addr;
  assign head_data_o   = mem_q[rd_q].data;
  assign head_killed_o = mem_q[rd_q].killed;
  assign live_mask_o   = live;

endmodule

// File: rtl/regs_wb_ctrl.sv
// Register-file writeback arbiter: primary ALU writes beat queued secondary writes.
// Optional head-age starvation guard compiled under REGS_WB_AGE_GUARD_EN.
module regs_wb_ctrl
  import regs_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pri_we,
  input  logic [ADDR_W-1:0] pri_addr,
  input  logic [DATA_W-1:0] pri_data,
  input  logic              sec_valid,
  input  logic [ADDR_W-1:0] sec_addr,
  input  logic [DATA_W-1:0] sec_data,
  output logic              sec_ready,
  output logic              L_S,
  output logic [ADDR_W-1:0] Wt_addr,
  output logic [DATA_W-1:0] Wt_data,
  output logic [31:0]       busy,
  output logic [2:0]        fifo_cnt,
  output logic              pri_stall
);

  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_killed;
  logic [31:0]       live_mask;

  logic              stall;
  logic              pri_issue;
  logic              head_live;
  logic              head_issue;
  logic              push;
  logic              push_kill;
  logic              pop;

  logic              ls_q, ls_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic [DATA_W-1:0] wt_data_q, wt_data_d;

  assign sec_ready  = (cnt < CNT_W'(FIFO_DEPTH)) && !rst;
  assign pri_issue  = pri_we && (pri_addr != '0) && !stall;
  assign head_live  = (cnt != '0) && !head_killed;
  assign head_issue = head_live && !pri_issue;
  assign push       = sec_valid && sec_ready && (sec_addr != '0);
  assign push_kill  = pri_issue && (sec_addr == pri_addr);
  // Killed heads drain even while the primary owns the write port.
  assign pop        = (cnt != '0) && (head_killed || !pri_issue);

  wb_fifo u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_addr_i  (sec_addr),
    .push_data_i  (sec_data),
    .push_kill_i  (push_kill),
    .pop_i        (pop),
    .kill_i       (pri_issue),
    .kill_addr_i  (pri_addr),
    .cnt_o        (cnt),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .head_killed_o(head_killed),
    .live_mask_o  (live_mask)
  );

  always_comb begin
    ls_d      = 1'b0;
    wt_addr_d = '0;
    wt_data_d = '0;
    if (pri_issue) begin
      ls_d      = 1'b1;
      wt_addr_d = pri_addr;
      wt_data_d = pri_data;
    end else if (head_issue) begin
      ls_d      = 1'b1;
      wt_addr_d = head_addr;
      wt_data_d = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ls_q      <= 1'b0;
      wt_addr_q <= '0;
      wt_data_q <= '0;
    end else begin
      ls_q      <= ls_d;
      wt_addr_q <= wt_addr_d;
      wt_data_q <= wt_data_d;
    end
  end

`ifdef REGS_WB_AGE_GUARD_EN
  logic [2:0] age_q, age_d;
  logic       stall_q, stall_d;

  // Age counts cycles a live head loses arbitration; reaching the limit
  // stalls the primary for one cycle so the head can issue.
  always_comb begin
    age_d = age_q;
    if (pop || !head_live) age_d = '0;
    else if (age_q != 3'(AGE_LIMIT)) age_d = age_q + 3'd1;
    stall_d = (age_d == 3'(AGE_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      stall_q <= stall_d;
    end
  end

  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

  assign pri_stall = stall;
  assign L_S       = ls_q;
  assign Wt_addr   = wt_addr_q;
  assign Wt_data   = wt_data_q;
  assign busy      = live_mask;
  assign fifo_cnt  = cnt;

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// Self-checking bench for regs_wb_ctrl: vector table plus multi-cycle sequences,
// with a latency-1 scoreboard on the register-file write port.
module tb_regs_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pri_we;
  logic [4:0]  pri_addr;
  logic [31:0] pri_data;
  logic        sec_valid;
  logic [4:0]  sec_addr;
  logic [31:0] sec_data;
  logic        sec_ready;
  logic        L_S;
  logic [4:0]  Wt_addr;
  logic [31:0] Wt_data;
  logic [31:0] busy;
  logic [2:0]  fifo_cnt;
  logic        pri_stall;

  always #5 clk = ~clk;

  regs_wb_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .pri_we   (pri_we),
    .pri_addr (pri_addr),
    .pri_data (pri_data),
    .sec_valid(sec_valid),
    .sec_addr (sec_addr),
    .sec_data (sec_data),
    .sec_ready(sec_ready),
    .L_S      (L_S),
    .Wt_addr  (Wt_addr),
    .Wt_data  (Wt_data),
    .busy     (busy),
    .fifo_cnt (fifo_cnt),
    .pri_stall(pri_stall)
  );

  typedef struct {
    logic        ls;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        sv;
    logic [4:0]  sa;
    logic [31:0] sd;
    logic        ls1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [31:0] busy1;
    logic [2:0]  cnt1;
    logic        ls2;
    logic [4:0]  a2;
    logic [31:0] d2;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vt[9];
  int   n_run  = 0;
  int   n_fail = 0;

`ifdef REGS_WB_AGE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue the write expected on the next cycle, then check it.
  task automatic cyc(input string nm,
                     input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                     input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                     input logic els, input logic [4:0] ea, input logic [31:0] ed);
    wr_t e;
    pri_we    = pw;
    pri_addr  = pa;
    pri_data  = pd;
    sec_valid = sv;
    sec_addr  = sa;
    sec_data  = sd;
    exp_q.push_back('{els, ea, ed});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({nm, " L_S"},     32'(L_S),     32'(e.ls));
    chk({nm, " Wt_addr"}, 32'(Wt_addr), 32'(e.a));
    chk({nm, " Wt_data"}, Wt_data,      e.d);
  endtask

  task automatic idle(input string nm, input logic els, input logic [4:0] ea, input logic [31:0] ed);
    cyc(nm, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, els, ea, ed);
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd5,  32'h11,       1'b1, 5'd6,  32'h22, 1'b1, 5'd5,  32'h11,       32'h40,  3'd1, 1'b1, 5'd6, 32'h22};
    vt[1] = '{1'b1, 5'd3,  32'h33,       1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  32'h33,       32'h0,   3'd0, 1'b0, 5'd0, 32'h0};
    vt[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h99, 1'b0, 5'd0,  32'h0,        32'h200, 3'd1, 1'b1, 5'd9, 32'h99};
    vt[3] = '{1'b1, 5'd0,  32'h5,        1'b1, 5'd0,  32'h6,  1'b0, 5'd0,  32'h0,        32'h0,   3'd0, 1'b0, 5'd0, 32'h0};
    vt[4] = '{1'b1, 5'd12, 32'hC,        1'b1, 5'd12, 32'hD,  1'b1, 5'd12, 32'hC,        32'h0,   3'd1, 1'b0, 5'd0, 32'h0};
    vt[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd1,  32'h1,  1'b1, 5'd31, 32'hFFFFFFFF, 32'h2,   3'd1, 1'b1, 5'd1, 32'h1};
    vt[6] = '{1'b1, 5'd0,  32'h5,        1'b1, 5'd4,  32'h44, 1'b0, 5'd0,  32'h0,        32'h10,  3'd1, 1'b1, 5'd4, 32'h44};
    vt[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h77, 1'b0, 5'd0,  32'h0,        32'h0,   3'd0, 1'b0, 5'd0, 32'h0};
    vt[8] = '{1'b0, 5'd7,  32'h70,       1'b1, 5'd7,  32'h71, 1'b0, 5'd0,  32'h0,        32'h80,  3'd1, 1'b1, 5'd7, 32'h71};

    rst = 1'b1;
    pri_we = 1'b0; pri_addr = '0; pri_data = '0;
    sec_valid = 1'b0; sec_addr = '0; sec_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset L_S",       32'(L_S),       32'h0);
    chk("reset Wt_addr",   32'(Wt_addr),   32'h0);
    chk("reset Wt_data",   Wt_data,        32'h0);
    chk("reset busy",      busy,           32'h0);
    chk("reset fifo_cnt",  32'(fifo_cnt),  32'h0);
    chk("reset pri_stall", 32'(pri_stall), 32'h0);
    chk("reset sec_ready", 32'(sec_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("post-reset sec_ready", 32'(sec_ready), 32'h1);

    for (int i = 0; i < 9; i++) begin
      cyc($sformatf("vec%0d", i), vt[i].pw, vt[i].pa, vt[i].pd, vt[i].sv, vt[i].sa, vt[i].sd,
          vt[i].ls1, vt[i].a1, vt[i].d1);
      chk($sformatf("vec%0d busy", i),     busy,           vt[i].busy1);
      chk($sformatf("vec%0d fifo_cnt", i), 32'(fifo_cnt),  32'(vt[i].cnt1));
      idle($sformatf("vec%0d drain", i), vt[i].ls2, vt[i].a2, vt[i].d2);
      chk($sformatf("vec%0d drain busy", i), busy,          32'h0);
      chk($sformatf("vec%0d drain cnt", i),  32'(fifo_cnt), 32'h0);
    end

    // Primary write to a queued address supersedes the queued value.
    cyc("kill0", 1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'hAA, 1'b1, 5'd1, 32'h1);
    chk("kill0 busy", busy, 32'h80);
    cyc("kill1", 1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hBB);
    chk("kill1 busy", busy, 32'h0);
    chk("kill1 cnt", 32'(fifo_cnt), 32'h1);
    idle("kill2", 1'b0, 5'd0, 32'h0);
    chk("kill2 cnt", 32'(fifo_cnt), 32'h0);
    idle("kill3", 1'b0, 5'd0, 32'h0);

    // Fill the queue behind a continuous primary, then pop once.
    for (int k = 0; k < 4; k++)
      cyc($sformatf("full_push%0d", k), 1'b1, 5'd1, 32'(k), 1'b1, 5'(10 + k), 32'hA0 + 32'(k),
          1'b1, 5'd1, 32'(k));
    chk("full cnt", 32'(fifo_cnt), 32'h4);
    chk("full sec_ready", 32'(sec_ready), 32'h0);
    chk("full busy", busy, 32'h3C00);
    cyc("full_hold", 1'b1, 5'd1, 32'h4, 1'b1, 5'd14, 32'hAE, 1'b1, 5'd1, 32'h4);
    chk("full_hold cnt", 32'(fifo_cnt), 32'h4);
    chk("full_hold sec_ready", 32'(sec_ready), 32'h0);
    cyc("full_pop", 1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hAE, 1'b1, 5'd10, 32'hA0);
    chk("full_pop cnt", 32'(fifo_cnt), 32'h3);
    chk("full_pop sec_ready", 32'(sec_ready), 32'h1);
    cyc("full_acc", 1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hAE, 1'b1, 5'd11, 32'hA1);
    chk("full_acc cnt", 32'(fifo_cnt), 32'h3);
    chk("full_acc busy", busy, 32'h7000);
    idle("full_d0", 1'b1, 5'd12, 32'hA2);
    idle("full_d1", 1'b1, 5'd13, 32'hA3);
    idle("full_d2", 1'b1, 5'd14, 32'hAE);
    chk("full drained cnt", 32'(fifo_cnt), 32'h0);

    // Address-0 traffic issues nothing; the queue uses the free port.
    cyc("a0_q", 1'b1, 5'd1, 32'h5, 1'b1, 5'd9, 32'h99, 1'b1, 5'd1, 32'h5);
    chk("a0_q cnt", 32'(fifo_cnt), 32'h1);
    chk("a0_q sec_ready", 32'(sec_ready), 32'h1);
    cyc("a0", 1'b1, 5'd0, 32'h7, 1'b1, 5'd0, 32'h8, 1'b1, 5'd9, 32'h99);
    chk("a0 cnt", 32'(fifo_cnt), 32'h0);
    chk("a0 busy", busy, 32'h0);
    idle("a0_idle", 1'b0, 5'd0, 32'h0);

    // Starvation: primary held on r2 while r8 waits in the queue.
    cyc("age0", 1'b1, 5'd2, 32'h200, 1'b1, 5'd8, 32'h88, 1'b1, 5'd2, 32'h200);
    chk("age0 pri_stall", 32'(pri_stall), 32'h0);
    for (int k = 1; k < 12; k++) begin
      if (GUARD && k == 8)
        cyc($sformatf("age%0d", k), 1'b1, 5'd2, 32'h200 + 32'(k), 1'b0, 5'd0, 32'h0,
            1'b1, 5'd8, 32'h88);
      else
        cyc($sformatf("age%0d", k), 1'b1, 5'd2, 32'h200 + 32'(k), 1'b0, 5'd0, 32'h0,
            1'b1, 5'd2, 32'h200 + 32'(k));
      chk($sformatf("age%0d pri_stall", k), 32'(pri_stall), 32'(GUARD && k == 7));
    end
    chk("age cnt", 32'(fifo_cnt), GUARD ? 32'h0 : 32'h1);
    if (GUARD) idle("age_rel", 1'b0, 5'd0, 32'h0);
    else       idle("age_rel", 1'b1, 5'd8, 32'h88);
    chk("age_rel cnt", 32'(fifo_cnt), 32'h0);

    // Reset in the middle of traffic discards everything queued or in flight.
    cyc("rt0", 1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20, 1'b1, 5'd1, 32'h1);
    cyc("rt1", 1'b1, 5'd1, 32'h2, 1'b1, 5'd21, 32'h21, 1'b1, 5'd1, 32'h2);
    chk("rt1 cnt", 32'(fifo_cnt), 32'h2);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc($sformatf("rst%0d", k), 1'b1, 5'd3, 32'h3, 1'b1, 5'd22, 32'h22, 1'b0, 5'd0, 32'h0);
      chk($sformatf("rst%0d cnt", k),       32'(fifo_cnt),  32'h0);
      chk($sformatf("rst%0d busy", k),      busy,           32'h0);
      chk($sformatf("rst%0d sec_ready", k), 32'(sec_ready), 32'h0);
      chk($sformatf("rst%0d pri_stall", k), 32'(pri_stall), 32'h0);
    end
    rst = 1'b0;
    pri_we = 1'b0;
    sec_valid = 1'b0;
    #1;
    chk("rst release sec_ready", 32'(sec_ready), 32'h1);
    idle("rst_after", 1'b0, 5'd0, 32'h0);
    chk("rst_after cnt", 32'(fifo_cnt), 32'h0);
    chk("rst_after busy", busy, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
